// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs opcode, register, funct and immediate fields
// into one word through a two-stage valid/ready pipeline, flagging bad immediates.
module inst_encoder #(
  parameter int CNT_W    = 16,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_inst,
  output logic                out_err_range,
  output logic                out_err_align,
  output logic                out_err_fmt,
  output logic [CNT_W-1:0]    enc_count,
  output logic [ERRCNT_W-1:0] err_count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3,
    FMT_U = 3'd4, FMT_J = 3'd5, FMT_Z = 3'd6, FMT_X = 3'd7
  } fmt_e;

  typedef struct packed {
    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  typedef struct packed {
    logic range;
    logic align;
    logic fmt;
  } err_t;

  logic                s1_valid_q, s1_valid_d;
  req_t                s1_req_q, s1_req_d;
  err_t                s1_err_q, s1_err_d;
  logic                s2_valid_q, s2_valid_d;
  logic [31:0]         s2_inst_q, s2_inst_d;
  err_t                s2_err_q, s2_err_d;
  logic [CNT_W-1:0]    enc_count_q, enc_count_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic  s2_load, out_fire;
  err_t  in_err;
  logic  sext11_ok, sext12_ok, sext20_ok;
  logic [31:0] packed_word;

  // A signed immediate fits when every bit above the field's sign bit matches it.
  assign sext11_ok = (&in_imm[31:11]) || ~(|in_imm[31:11]);
  assign sext12_ok = (&in_imm[31:12]) || ~(|in_imm[31:12]);
  assign sext20_ok = (&in_imm[31:20]) || ~(|in_imm[31:20]);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_err = '0;
    case (fmt_e'(in_fmt))
      FMT_I, FMT_S: in_err.range = !sext11_ok;
      FMT_B: begin
        in_err.range = !sext12_ok;
        in_err.align = in_imm[0];
      end
      FMT_U: in_err.align = |in_imm[11:0];
      FMT_J: begin
        in_err.range = !sext20_ok;
        in_err.align = in_imm[0];
      end
      FMT_Z: in_err.range = |in_imm[31:5];
      FMT_X: in_err.fmt   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    packed_word = {s1_req_q.funct7, s1_req_q.rs2, s1_req_q.rs1,
                   s1_req_q.funct3, s1_req_q.rd, s1_req_q.opcode};
    case (s1_req_q.fmt)
      FMT_I: packed_word[31:20] = s1_req_q.imm[11:0];
      FMT_S: begin
        packed_word[31:25] = s1_req_q.imm[11:5];
        packed_word[11:7]  = s1_req_q.imm[4:0];
      end
      FMT_B: begin
        packed_word[31]    = s1_req_q.imm[12];
        packed_word[30:25] = s1_req_q.imm[10:5];
        packed_word[11:8]  = s1_req_q.imm[4:1];
        packed_word[7]     = s1_req_q.imm[11];
      end
      FMT_U: packed_word[31:12] = s1_req_q.imm[31:12];
      FMT_J: begin
        packed_word[31]    = s1_req_q.imm[20];
        packed_word[30:21] = s1_req_q.imm[10:1];
        packed_word[20]    = s1_req_q.imm[11];
        packed_word[19:12] = s1_req_q.imm[19:12];
      end
      FMT_Z: packed_word[19:15] = s1_req_q.imm[4:0];
      default: ;
    endcase
  end

  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    out_fire = s2_valid_q && out_ready;

    s1_valid_d = s1_valid_q;
    s1_req_d   = s1_req_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_inst_d  = s2_inst_q;
    s2_err_d   = s2_err_q;

    // Flush beats any same-cycle input; an output handshake still counts below.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_d = in_valid;
        if (in_valid) begin
          s1_req_d = '{fmt: fmt_e'(in_fmt), opcode: in_opcode, funct3: in_funct3,
                       funct7: in_funct7, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                       imm: in_imm};
          s1_err_d = in_err;
        end
      end
      if (s2_load) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_inst_d = packed_word;
          s2_err_d  = s1_err_q;
        end
      end
    end

    enc_count_d = enc_count_q;
    err_count_d = err_count_q;
    if (out_fire) begin
      enc_count_d = enc_count_q + CNT_W'(1);
      if ((|s2_err_q) && (err_count_q != {ERRCNT_W{1'b1}}))
        err_count_d = err_count_q + ERRCNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // The payload registers are reset as well, so out_inst and flags read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_req_q    <= '0;
      s1_err_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_inst_q   <= '0;
      s2_err_q    <= '0;
      enc_count_q <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_req_q    <= s1_req_d;
      s1_err_q    <= s1_err_d;
      s2_valid_q  <= s2_valid_d;
      s2_inst_q   <= s2_inst_d;
      s2_err_q    <= s2_err_d;
      enc_count_q <= enc_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_inst      = s2_inst_q;
  assign out_err_range = s2_err_q.range;
  assign out_err_align = s2_err_q.align;
  assign out_err_fmt   = s2_err_q.fmt;
  assign enc_count     = enc_count_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-computed RV32 words, flags, latency,
// backpressure, flush, async reset and error-counter saturation.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_inst;
  logic        out_err_range, out_err_align, out_err_fmt;
  logic [15:0] enc_count;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;
  int exp_enc = 0;
  int exp_err = 0;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp_inst;
    logic [2:0]  exp_flags; // {range, align, fmt}
  } vec_t;

  vec_t vecs[10];

  inst_encoder #(.CNT_W(16), .ERRCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_err_range(out_err_range), .out_err_align(out_err_align),
    .out_err_fmt(out_err_fmt),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    in_fmt    = v.fmt;
    in_opcode = v.op;
    in_funct3 = v.f3;
    in_funct7 = v.f7;
    in_rd     = v.rd;
    in_rs1    = v.rs1;
    in_rs2    = v.rs2;
    in_imm    = v.imm;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    exp_enc = 0;
    exp_err = 0;
  endtask

  // One isolated word: accept, check two-edge latency, contents, then counters.
  task automatic encode_one(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    in_valid = 1'b1;
    check($sformatf("%s:in_ready", tag), in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check($sformatf("%s:early_valid", tag), out_valid, 0);
    @(posedge clk); #1;
    check($sformatf("%s:out_valid", tag), out_valid, 1);
    check($sformatf("%s:inst", tag), out_inst, v.exp_inst);
    check($sformatf("%s:flags", tag), {out_err_range, out_err_align, out_err_fmt}, v.exp_flags);
    exp_enc++;
    if (v.exp_flags != 3'b000 && exp_err != 255) exp_err++;
    @(posedge clk); #1;
    check($sformatf("%s:enc_count", tag), enc_count, exp_enc);
    check($sformatf("%s:err_count", tag), err_count, exp_err);
  endtask

  initial begin
    int acc;
    logic [31:0] held;

    //          fmt   op     f3    f7     rd     rs1    rs2    imm           inst          flags
    vecs[0] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'hFFFFFFFF, 32'hFFF00093, 3'b000};
    vecs[1] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFC, 32'hFE000EE3, 3'b000};
    vecs[2] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0,  5'd0,  5'd0,  32'h00000003, 32'h00000163, 3'b010};
    vecs[3] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00000800, 32'h001000EF, 3'b000};
    vecs[4] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5,  5'd0,  5'd0,  32'h12345000, 32'h123452B7, 3'b000};
    vecs[5] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1,  5'd0,  5'd0,  32'h00000800, 32'h80000093, 3'b100};
    vecs[6] = '{3'd7, 7'h33, 3'd0, 7'h20, 5'd3,  5'd1,  5'd2,  32'h00000000, 32'h402081B3, 3'b001};
    vecs[7] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0,  5'd2,  5'd1,  32'hFFFFFFFC, 32'hFE112E23, 3'b000};
    vecs[8] = '{3'd6, 7'h73, 3'd5, 7'h18, 5'd1,  5'd0,  5'd0,  32'h00000015, 32'h300AD0F3, 3'b000};
    vecs[9] = '{3'd6, 7'h73, 3'd5, 7'h18, 5'd1,  5'd0,  5'd0,  32'h00000020, 32'h300050F3, 3'b100};

    // Reset state
    #2;
    check("rst:out_valid", out_valid, 0);
    check("rst:out_inst", out_inst, 0);
    check("rst:flags", {out_err_range, out_err_align, out_err_fmt}, 0);
    check("rst:enc_count", enc_count, 0);
    check("rst:err_count", err_count, 0);
    reset_dut();
    check("rst:in_ready", in_ready, 1);

    // Directed encodings
    encode_one("i_neg1", vecs[0]);
    encode_one("b_neg4", vecs[1]);
    encode_one("b_align", vecs[2]);
    encode_one("j_800", vecs[3]);
    encode_one("u_lui", vecs[4]);
    encode_one("i_range", vecs[5]);
    encode_one("fmt7", vecs[6]);
    encode_one("s_sw", vecs[7]);
    encode_one("z_ok", vecs[8]);
    encode_one("z_range", vecs[9]);

    // Backpressure: in_valid held 4 cycles with out_ready low
    reset_dut();
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(acc == 0 ? vecs[4] : vecs[3]);
      in_valid = 1'b1;
      if (in_ready) acc++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp:accepted", acc, 2);
    check("bp:in_ready", in_ready, 0);
    check("bp:out_valid", out_valid, 1);
    held = vecs[4].exp_inst;
    check("bp:inst0", out_inst, held);
    repeat (2) @(posedge clk);
    #1;
    check("bp:inst_stable", out_inst, held);
    check("bp:flags_stable", {out_err_range, out_err_align, out_err_fmt}, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp:second_valid", out_valid, 1);
    check("bp:inst1", out_inst, vecs[3].exp_inst);
    @(posedge clk); #1;
    check("bp:drained", out_valid, 0);
    check("bp:enc_count", enc_count, 2);

    // Flush with both stages full and a new input offered
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      drive(vecs[c]);
      in_valid = 1'b1;
    end
    @(negedge clk);
    check("fl:full", {out_valid, in_ready}, 2'b10);
    drive(vecs[2]);
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl:out_valid", out_valid, 0);
    check("fl:in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("fl:nothing_left", out_valid, 0);
    check("fl:enc_count", enc_count, 2);

    // Reset asserted with a word at the output
    out_ready = 1'b0;
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("ar:pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("ar:out_valid", out_valid, 0);
    check("ar:out_inst", out_inst, 0);
    check("ar:enc_count", enc_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Saturation: 300 back-to-back errored words
    @(negedge clk);
    drive(vecs[6]);
    in_valid = 1'b1;
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sat:err_count", err_count, 8'hFF);
    check("sat:enc_count", enc_count, 300);
    check("sat:idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
